// File: rtl/text_buffer_if.sv
// Host, video and command signals of the text buffer, bundled for port connection.
// Handshake: a host access is taken on a rising edge where host_ce=1 and host_ready=1; video reads are never refused.
interface text_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 5,
    parameter int COL_W  = 7
);
    logic              host_ce;
    logic              host_wre;
    logic [ROW_W-1:0]  host_row;
    logic [COL_W-1:0]  host_col;
    logic [DATA_W-1:0] host_din;
    logic [DATA_W-1:0] host_dout;
    logic              host_ready;
    logic              vid_ce;
    logic [ROW_W-1:0]  vid_row;
    logic [COL_W-1:0]  vid_col;
    logic [DATA_W-1:0] vid_dout;
    logic              cmd_clear;
    logic              cmd_scroll;
    logic              busy;
    logic [ROW_W-1:0]  row_base;

    modport master (
        output host_ce, host_wre, host_row, host_col, host_din,
        output vid_ce, vid_row, vid_col, cmd_clear, cmd_scroll,
        input  host_dout, host_ready, vid_dout, busy, row_base
    );

    modport slave (
        input  host_ce, host_wre, host_row, host_col, host_din,
        input  vid_ce, vid_row, vid_col, cmd_clear, cmd_scroll,
        output host_dout, host_ready, vid_dout, busy, row_base
    );
endinterface

// File: rtl/text_buffer.sv
// Dual-port VGA character buffer: host read/write, 2-cycle video read, and
// hardware clear / scroll-up implemented through a circular physical row base.
module text_buffer #(
  parameter int                DATA_W    = 8,
  parameter int                COLS      = 80,
  parameter int                ROWS      = 30,
  parameter int                ADDR_W    = 12,
  parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20,
  parameter                    INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         reset,
  text_buffer_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W:0]    ROWS_EXT  = (ROW_W + 1)'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(CELLS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_SCROLL = 2'd2;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic [1:0]        state;
  logic [ROW_W-1:0]  row_base_q;
  logic [ADDR_W-1:0] sweep_addr;
  logic [ADDR_W-1:0] sweep_last;

  // Logical row plus base wraps at most once, so one conditional subtract replaces a modulo.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] base);
    logic [ROW_W:0] sum;
    sum = {1'b0, row} + {1'b0, base};
    if (sum >= ROWS_EXT)
      sum = sum - ROWS_EXT;
    return ADDR_W'(sum) * COLS_A + ADDR_W'(col);
  endfunction

  logic              idle;
  logic              host_ok;
  logic              host_wr;
  logic              host_rd;
  logic [ADDR_W-1:0] host_addr;
  logic              vid_ok;
  logic [ADDR_W-1:0] vid_addr;
  logic [ROW_W-1:0]  row_base_next;
  logic [ADDR_W-1:0] fill_row_addr;

  assign idle          = (state == ST_IDLE);
  assign host_ok       = (bus.host_row <= ROW_LAST) && (bus.host_col <= COL_LAST);
  assign host_addr     = phys_addr(bus.host_row, bus.host_col, row_base_q);
  assign host_wr       = idle && bus.host_ce && bus.host_wre && host_ok;
  assign host_rd       = idle && bus.host_ce && !bus.host_wre && host_ok;
  assign vid_ok        = (bus.vid_row <= ROW_LAST) && (bus.vid_col <= COL_LAST);
  assign vid_addr      = phys_addr(bus.vid_row, bus.vid_col, row_base_q);
  assign row_base_next = (row_base_q == ROW_LAST) ? '0 : row_base_q + 1'b1;
  assign fill_row_addr = ADDR_W'(row_base_q) * COLS_A;

  // Single write port: host only writes in IDLE, the sweep only outside it.
  // Writes are suppressed under reset so an aborted sweep stops exactly where it was.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!reset) begin
      if (host_wr) begin
        mem_we = 1'b1;
        mem_wa = host_addr;
        mem_wd = bus.host_din;
      end else if (!idle) begin
        mem_we = 1'b1;
        mem_wa = sweep_addr;
        mem_wd = FILL_CHAR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  logic [DATA_W-1:0] host_dout_q;

  always_ff @(posedge clk) begin
    if (reset)
      host_dout_q <= '0;
    else if (host_rd)
      host_dout_q <= mem[host_addr];
  end

  logic              vid_v1;
  logic              vid_oor1;
  logic [DATA_W-1:0] vid_q1;
  logic [DATA_W-1:0] vid_dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_v1     <= 1'b0;
      vid_oor1   <= 1'b0;
      vid_q1     <= '0;
      vid_dout_q <= '0;
    end else begin
      vid_v1   <= bus.vid_ce;
      vid_oor1 <= !vid_ok;
      if (bus.vid_ce)
        vid_q1 <= mem[vid_addr];
      if (vid_v1)
        vid_dout_q <= vid_oor1 ? FILL_CHAR : vid_q1;
    end
  end

  // Clear takes priority over scroll; commands outside IDLE are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      row_base_q <= '0;
      sweep_addr <= '0;
      sweep_last <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_clear) begin
            state      <= ST_CLEAR;
            sweep_addr <= '0;
            sweep_last <= CELL_LAST;
            row_base_q <= '0;
          end else if (bus.cmd_scroll) begin
            state      <= ST_SCROLL;
            sweep_addr <= fill_row_addr;
            sweep_last <= fill_row_addr + COLS_A - 1'b1;
            row_base_q <= row_base_next;
          end
        end
        ST_CLEAR, ST_SCROLL: begin
          if (sweep_addr == sweep_last)
            state <= ST_IDLE;
          else
            sweep_addr <= sweep_addr + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.host_dout  = host_dout_q;
  assign bus.host_ready = idle;
  assign bus.vid_dout   = vid_dout_q;
  assign bus.busy       = !idle;
  assign bus.row_base   = row_base_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer: stimulus pushes expected read data into queues,
// a monitor pops and compares when host/video read data becomes valid.
module tb_text_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    text_buffer_if #(.DATA_W(8), .ROW_W(5), .COL_W(7)) bus ();

    text_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] host_exp_q[$];
    logic [7:0] vid_exp_q[$];
    logic       host_chk = 1'b0;
    logic       hp1 = 1'b0;
    logic       vp1 = 1'b0;
    logic       vp2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: track read latency from the issued strobes and compare off the active edge.
    always @(posedge clk) begin
        hp1 <= host_chk;
        vp1 <= bus.vid_ce;
        vp2 <= vp1;
    end

    always @(negedge clk) begin
        if (hp1) begin
            if (host_exp_q.size() == 0) check("host_q_underflow", 32'd1, 32'd0);
            else check("host_dout", 32'(bus.host_dout), 32'(host_exp_q.pop_front()));
        end
        if (vp2) begin
            if (vid_exp_q.size() == 0) check("vid_q_underflow", 32'd1, 32'd0);
            else check("vid_dout", 32'(bus.vid_dout), 32'(vid_exp_q.pop_front()));
        end
    end

    // Driver tasks: entered just after a rising edge, occupy exactly one cycle.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int r, input int c, input logic [7:0] d);
        bus.host_ce = 1'b1; bus.host_wre = 1'b1;
        bus.host_row = 5'(r); bus.host_col = 7'(c); bus.host_din = d;
        tick(1);
        bus.host_ce = 1'b0; bus.host_wre = 1'b0;
    endtask

    task automatic host_read(input int r, input int c, input logic [7:0] exp);
        bus.host_ce = 1'b1; bus.host_wre = 1'b0;
        bus.host_row = 5'(r); bus.host_col = 7'(c);
        host_exp_q.push_back(exp);
        host_chk = 1'b1;
        tick(1);
        bus.host_ce = 1'b0; host_chk = 1'b0;
    endtask

    task automatic vid_read(input int r, input int c, input logic [7:0] exp);
        bus.vid_ce = 1'b1; bus.vid_row = 5'(r); bus.vid_col = 7'(c);
        vid_exp_q.push_back(exp);
        tick(1);
        bus.vid_ce = 1'b0;
    endtask

    task automatic pulse_cmd(input logic clr, input logic scr);
        bus.cmd_clear = clr; bus.cmd_scroll = scr;
        tick(1);
        bus.cmd_clear = 1'b0; bus.cmd_scroll = 1'b0;
    endtask

    // Counts busy cycles on falling edges, bounded so a stuck FSM still ends the run.
    task automatic count_busy(input int start, output int n);
        n = start;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        tick(1);
    endtask

    int n;

    initial begin
        reset = 1'b1;
        bus.host_ce = 1'b0; bus.host_wre = 1'b0; bus.host_row = '0; bus.host_col = '0;
        bus.host_din = '0; bus.vid_ce = 1'b0; bus.vid_row = '0; bus.vid_col = '0;
        bus.cmd_clear = 1'b0; bus.cmd_scroll = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_row_base", 32'(bus.row_base), 32'd0);
        check("rst_host_dout", 32'(bus.host_dout), 32'd0);
        check("rst_vid_dout", 32'(bus.vid_dout), 32'd0);
        check("rst_ready", 32'(bus.host_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'd0);
        tick(1);

        // Full clear, then sweep the whole screen through the video port.
        pulse_cmd(1'b1, 1'b0);
        count_busy(0, n);
        check("clear_busy_cycles", 32'(n), 32'd2400);
        check("clear_row_base", 32'(bus.row_base), 32'd0);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                vid_read(r, c, 8'h20);
        tick(3);

        // Basic write/read and out-of-range handling.
        host_write(0, 0, 8'h41);
        host_read(0, 0, 8'h41);
        vid_read(0, 0, 8'h41);
        host_write(30, 0, 8'h77);
        host_write(0, 80, 8'h77);
        host_read(1, 0, 8'h20);
        host_read(0, 0, 8'h41);
        host_read(0, 80, 8'h41);
        host_read(31, 0, 8'h41);
        vid_read(0, 80, 8'h20);
        vid_read(30, 0, 8'h20);
        vid_read(0, 0, 8'h41);
        tick(4);
        check("vid_hold", 32'(bus.vid_dout), 32'h41);

        // Scroll with a host write and a second scroll issued while busy.
        host_write(1, 5, 8'h31);
        pulse_cmd(1'b0, 1'b1);
        bus.host_ce = 1'b1; bus.host_wre = 1'b1; bus.host_row = 5'd2; bus.host_col = 7'd3;
        bus.host_din = 8'h99; bus.cmd_scroll = 1'b1;
        @(negedge clk);
        check("busy_ready", 32'(bus.host_ready), 32'd0);
        check("scroll_state", 32'(dbg_state), 32'd2);
        tick(1);
        bus.host_ce = 1'b0; bus.host_wre = 1'b0; bus.cmd_scroll = 1'b0;
        count_busy(1, n);
        check("scroll_busy_cycles", 32'(n), 32'd80);
        check("scroll_row_base", 32'(bus.row_base), 32'd1);
        vid_read(0, 5, 8'h31);
        for (int c = 0; c < 80; c++)
            vid_read(29, c, 8'h20);
        host_read(2, 3, 8'h20);
        tick(3);

        // Simultaneous clear and scroll: clear only.
        pulse_cmd(1'b1, 1'b1);
        @(negedge clk);
        check("clear_state", 32'(dbg_state), 32'd1);
        count_busy(1, n);
        check("both_busy_cycles", 32'(n), 32'd2400);
        check("both_row_base", 32'(bus.row_base), 32'd0);
        vid_read(0, 5, 8'h20);
        tick(3);

        // 30 scrolls: base walks 1..29 then wraps.
        host_write(29, 9, 8'h62);
        for (int k = 1; k <= 29; k++) begin
            pulse_cmd(1'b0, 1'b1);
            count_busy(0, n);
            check("walk_row_base", 32'(bus.row_base), 32'(k));
        end
        vid_read(0, 9, 8'h62);
        tick(3);
        pulse_cmd(1'b0, 1'b1);
        count_busy(0, n);
        check("wrap_busy_cycles", 32'(n), 32'd80);
        check("wrap_row_base", 32'(bus.row_base), 32'd0);
        vid_read(29, 9, 8'h20);
        host_read(0, 0, 8'h20);
        tick(3);

        // Reset partway through a clear: cells 0..99 filled, 100+ untouched.
        host_write(1, 19, 8'h5a);
        host_write(1, 20, 8'h5a);
        host_write(2, 0, 8'h5a);
        pulse_cmd(1'b1, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_row_base", 32'(bus.row_base), 32'd0);
        check("abort_ready", 32'(bus.host_ready), 32'd1);
        tick(1);
        host_read(1, 19, 8'h20);
        host_read(1, 20, 8'h5a);
        host_read(2, 0, 8'h5a);
        vid_read(0, 80, 8'h20);
        vid_read(1, 20, 8'h5a);
        tick(4);

        check("host_q_empty", 32'(host_exp_q.size()), 32'd0);
        check("vid_q_empty", 32'(vid_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
